// File: rtl/alu_pkg.sv
// Function-code encodings for the execute-stage ALU, shared by the ALU and the
// instruction decoder.
package alu_pkg;

  localparam int unsigned FUNC_W = 5;

  localparam logic [FUNC_W-1:0] FUNC_ADD  = 5'h00;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 5'h01;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 5'h04;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 5'h05;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 5'h06;
  localparam logic [FUNC_W-1:0] FUNC_MVHI = 5'h0B;
  localparam logic [FUNC_W-1:0] FUNC_NAND = 5'h0C;
  localparam logic [FUNC_W-1:0] FUNC_NOR  = 5'h0D;
  localparam logic [FUNC_W-1:0] FUNC_XNOR = 5'h0E;

  // Compares: bits [1:0] pick the base test, bit 3 inverts it.
  localparam logic [FUNC_W-1:0] FUNC_F    = 5'h10;
  localparam logic [FUNC_W-1:0] FUNC_EQ   = 5'h11;
  localparam logic [FUNC_W-1:0] FUNC_LT   = 5'h12;
  localparam logic [FUNC_W-1:0] FUNC_LTE  = 5'h13;
  localparam logic [FUNC_W-1:0] FUNC_T    = 5'h18;
  localparam logic [FUNC_W-1:0] FUNC_NE   = 5'h19;
  localparam logic [FUNC_W-1:0] FUNC_GTE  = 5'h1A;
  localparam logic [FUNC_W-1:0] FUNC_GT   = 5'h1B;

  localparam logic [1:0] CMP_SEL_F   = 2'd0;
  localparam logic [1:0] CMP_SEL_EQ  = 2'd1;
  localparam logic [1:0] CMP_SEL_LT  = 2'd2;
  localparam logic [1:0] CMP_SEL_LTE = 2'd3;

endpackage

// File: rtl/alu_cmp.sv
// Combinational signed compare: derives eq/lt of two two's-complement words and
// returns the selected (optionally inverted) 1-bit compare result.
module alu_cmp
  import alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  input  logic [1:0]           i_sel,
  input  logic                 i_inv,
  output logic                 o_flag
);

  logic w_eq;
  logic w_lt;
  logic w_base;

  assign w_eq = (i_a == i_b);
  assign w_lt = ($signed(i_a) < $signed(i_b));

  always_comb begin
    w_base = 1'b0;
    case (i_sel)
      CMP_SEL_F:   w_base = 1'b0;
      CMP_SEL_EQ:  w_base = w_eq;
      CMP_SEL_LT:  w_base = w_lt;
      CMP_SEL_LTE: w_base = w_lt | w_eq;
      default:     w_base = 1'b0;
    endcase
  end

  // Inversion turns F/EQ/LT/LTE into T/NE/GTE/GT.
  assign o_flag = w_base ^ i_inv;

endmodule

// File: rtl/alu.sv
// Registered execute-stage ALU: combinational op mux into a one-cycle result
// register with a valid strobe that tracks in_valid.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in1,
  input  logic [WORD_SIZE-1:0] in2,
  input  logic [FUNC_W-1:0]    func,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out
);

  localparam int unsigned HALF = WORD_SIZE / 2;

  logic [WORD_SIZE-1:0] w_result;
  logic                 w_cmp_flag;
  logic [WORD_SIZE-1:0] r_out;
  logic                 r_out_valid;

  alu_cmp #(.WORD_SIZE(WORD_SIZE)) u_cmp (
    .i_a    (in1),
    .i_b    (in2),
    .i_sel  (func[1:0]),
    .i_inv  (func[3]),
    .o_flag (w_cmp_flag)
  );

  always_comb begin
    w_result = '0;
    case (func)
      FUNC_ADD:  w_result = in1 + in2;
      FUNC_SUB:  w_result = in1 - in2;
      FUNC_AND:  w_result = in1 & in2;
      FUNC_OR:   w_result = in1 | in2;
      FUNC_XOR:  w_result = in1 ^ in2;
      FUNC_NAND: w_result = ~(in1 & in2);
      FUNC_NOR:  w_result = ~(in1 | in2);
      FUNC_XNOR: w_result = ~(in1 ^ in2);
      FUNC_MVHI: w_result = {in2[HALF-1:0], {HALF{1'b0}}};
      FUNC_F, FUNC_EQ, FUNC_LT, FUNC_LTE,
      FUNC_T, FUNC_NE, FUNC_GTE, FUNC_GT:
                 w_result = {{(WORD_SIZE-1){1'b0}}, w_cmp_flag};
      default:   w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) r_out <= w_result;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table applied back to back,
// plus hand sequences for hold, undefined codes and asynchronous reset.
module tb_alu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic [4:0]    func;
  logic          out_valid;
  logic [W-1:0]  out;

  int n_pass;
  int n_total;

  alu #(.WORD_SIZE(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .func      (func),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [4:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic add_vec(input string name, input logic [4:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
    vec_t v;
    v.name = name; v.f = f; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    func = '0;

    add_vec("add",        FUNC_ADD,  32'd3, 32'd5, 32'd8);
    add_vec("sub",        FUNC_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE);
    add_vec("and",        FUNC_AND,  32'd3, 32'd5, 32'h0000_0001);
    add_vec("or",         FUNC_OR,   32'd3, 32'd5, 32'h0000_0007);
    add_vec("xor",        FUNC_XOR,  32'd3, 32'd5, 32'h0000_0006);
    add_vec("nand",       FUNC_NAND, 32'd3, 32'd5, 32'hFFFF_FFFE);
    add_vec("nor",        FUNC_NOR,  32'd3, 32'd5, 32'hFFFF_FFF8);
    add_vec("xnor",       FUNC_XNOR, 32'd3, 32'd5, 32'hFFFF_FFF9);
    add_vec("mvhi",       FUNC_MVHI, 32'hDEAD_BEEF, 32'd5, 32'h0005_0000);
    add_vec("undef_1f",   5'h1F,     32'd3, 32'd5, 32'h0);
    add_vec("mvhi_hi",    FUNC_MVHI, 32'h0, 32'h1234_5678, 32'h5678_0000);
    add_vec("undef_02",   5'h02,     32'd3, 32'd5, 32'h0);
    add_vec("add_wrap",   FUNC_ADD,  32'hFFFF_FFFF, 32'd1, 32'h0);
    add_vec("sub_wrap",   FUNC_SUB,  32'd0, 32'd1, 32'hFFFF_FFFF);
    add_vec("cmp_t",      FUNC_T,    32'd3, 32'd5, 32'd1);
    add_vec("cmp_f",      FUNC_F,    32'd3, 32'd5, 32'd0);
    add_vec("eq_35",      FUNC_EQ,   32'd3, 32'd5, 32'd0);
    add_vec("eq_33",      FUNC_EQ,   32'd3, 32'd3, 32'd1);
    add_vec("ne_35",      FUNC_NE,   32'd3, 32'd5, 32'd1);
    add_vec("ne_33",      FUNC_NE,   32'd3, 32'd3, 32'd0);
    add_vec("lt_m1_1",    FUNC_LT,   32'hFFFF_FFFF, 32'd1, 32'd1);
    add_vec("lt_min_max", FUNC_LT,   32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
    add_vec("gt_min_max", FUNC_GT,   32'h8000_0000, 32'h7FFF_FFFF, 32'd0);
    add_vec("gt_1_m1",    FUNC_GT,   32'd1, 32'hFFFF_FFFF, 32'd1);
    add_vec("lt_44",      FUNC_LT,   32'd4, 32'd4, 32'd0);
    add_vec("lte_44",     FUNC_LTE,  32'd4, 32'd4, 32'd1);
    add_vec("lte_54",     FUNC_LTE,  32'd5, 32'd4, 32'd0);
    add_vec("gte_44",     FUNC_GTE,  32'd4, 32'd4, 32'd1);
    add_vec("gte_m1_0",   FUNC_GTE,  32'hFFFF_FFFF, 32'd0, 32'd0);
    add_vec("undef_14",   5'h14,     32'd3, 32'd5, 32'h0);

    #1;
    check("reset_out",   out, '0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back issue: one vector per cycle, result checked after the edge.
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      func = vecs[i].f;
      in1  = vecs[i].a;
      in2  = vecs[i].b;
      @(posedge clk);
      #1;
      check(vecs[i].name, out, vecs[i].exp);
      check({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end

    // Hold: load a known value, then drop in_valid with different operands.
    func = FUNC_ADD; in1 = 32'd100; in2 = 32'd23;
    @(posedge clk); #1;
    check("hold_load", out, 32'd123);
    @(negedge clk);
    in_valid = 1'b0;
    func = FUNC_XOR; in1 = 32'hFFFF_0000; in2 = 32'h0000_FFFF;
    @(posedge clk); #1;
    check("hold_out",   out, 32'd123);
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("hold_out2",  out, 32'd123);

    // Async reset mid-cycle with an op in flight: cleared immediately, no edge.
    @(negedge clk);
    in_valid = 1'b1;
    func = FUNC_ADD; in1 = 32'd3; in2 = 32'd5;
    @(posedge clk); #1;
    check("pre_rst_out", out, 32'd8);
    @(negedge clk);
    func = FUNC_OR; in1 = 32'hA5A5_0000; in2 = 32'h0000_5A5A;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out",   out, '0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("rst_held_out",   out, '0);
    check("rst_held_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_out",   out, '0);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("post_rst_op",    out, 32'hA5A5_5A5A);
    check("post_rst_vld",   {31'd0, out_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
